// File: rtl/cla_pipe_addsub.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready global stall.
// Optional: define CLA_PIPE_SAT_EN to clamp out_sum on overflow.

// Segment adder: 4-bit group lookahead, groups chained by 4-group lookahead blocks.
module cla_seg #(
  parameter int unsigned NG = 1
) (
  input  logic [4*NG-1:0] a,
  input  logic [4*NG-1:0] b,
  input  logic            cin,
  output logic [4*NG-1:0] sum,
  output logic            cout
);
  logic [4*NG-1:0] g, p, c;
  logic [NG-1:0]   gg, gp;
  logic [NG:0]     gc;

  always_comb begin
    g  = a & b;
    p  = a | b;
    gg = '0;
    gp = '0;
    for (int j = 0; j < int'(NG); j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
  end

  // Group carries: each block of four groups looks ahead from its own block carry-in.
  always_comb begin
    logic [NG:0] gc_v;
    logic        acc, t;
    int          bb;
    gc_v    = '0;
    gc_v[0] = cin;
    for (int j = 0; j < int'(NG); j++) begin
      bb  = j - (j % 4);
      acc = gc_v[bb];
      for (int i = bb; i <= j; i++) acc = acc & gp[i];
      for (int i = bb; i <= j; i++) begin
        t = gg[i];
        for (int k = i + 1; k <= j; k++) t = t & gp[k];
        acc = acc | t;
      end
      gc_v[j+1] = acc;
    end
    gc = gc_v;
  end

  always_comb begin
    logic acc, t;
    c = '0;
    for (int j = 0; j < int'(NG); j++) begin
      for (int bi = 0; bi < 4; bi++) begin
        acc = gc[j];
        for (int i = 0; i < bi; i++) acc = acc & p[4*j+i];
        for (int i = 0; i < bi; i++) begin
          t = g[4*j+i];
          for (int k = i + 1; k < bi; k++) t = t & p[4*j+k];
          acc = acc | t;
        end
        c[4*j+bi] = acc;
      end
    end
    sum  = a ^ b ^ c;
    cout = gc[NG];
  end
endmodule

module cla_pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int unsigned NG   = WIDTH / 4;
  localparam int unsigned BASE = NG / STAGES;
  localparam int unsigned G0   = BASE + (NG % STAGES);

  logic             advance;
  logic             out_valid_q, out_valid_d, out_cout_q, out_cout_d, out_ovf_q, out_ovf_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_valid, fin_cout, fin_ovf;

  assign advance  = out_ready || !out_valid_q;
  assign in_ready = advance;

  for (genvar s = 0; s < STAGES; s++) begin : g_seg
    localparam int unsigned LO  = (s == 0) ? 0 : 4 * (G0 - BASE + s * BASE);
    localparam int unsigned NGS = (s == 0) ? G0 : BASE;
    localparam int unsigned HI  = LO + 4 * NGS;

    logic [WIDTH-1:LO] a_i, bx_i;
    logic [HI-1:0]     sum_all;
    logic [HI-LO-1:0]  seg_sum;
    logic              c_i, v_i, sub_i, sgn_i, seg_cout;

    if (s == 0) begin : g_src
      assign a_i     = in_a;
      assign bx_i    = in_b ^ {WIDTH{in_sub}};
      assign c_i     = in_sub;
      assign v_i     = in_valid;
      assign sub_i   = in_sub;
      assign sgn_i   = in_signed;
      assign sum_all = seg_sum;
    end else begin : g_src
      assign a_i     = g_seg[s-1].g_reg.a_q;
      assign bx_i    = g_seg[s-1].g_reg.bx_q;
      assign c_i     = g_seg[s-1].g_reg.c_q;
      assign v_i     = g_seg[s-1].g_reg.v_q;
      assign sub_i   = g_seg[s-1].g_reg.sub_q;
      assign sgn_i   = g_seg[s-1].g_reg.sgn_q;
      assign sum_all = {seg_sum, g_seg[s-1].g_reg.sum_q};
    end

    cla_seg #(.NG(NGS)) u_seg (
      .a   (a_i[HI-1:LO]),
      .b   (bx_i[HI-1:LO]),
      .cin (c_i),
      .sum (seg_sum),
      .cout(seg_cout)
    );

    if (s < STAGES - 1) begin : g_reg
      // Unconsumed operand bits skew forward; finished low sum bits de-skew forward.
      logic [WIDTH-1:HI] a_q, a_d, bx_q, bx_d;
      logic [HI-1:0]     sum_q, sum_d;
      logic              c_q, c_d, v_q, v_d, sub_q, sub_d, sgn_q, sgn_d;

      always_comb begin
        a_d   = a_q;
        bx_d  = bx_q;
        sum_d = sum_q;
        c_d   = c_q;
        v_d   = v_q;
        sub_d = sub_q;
        sgn_d = sgn_q;
        if (advance) begin
          a_d   = a_i[WIDTH-1:HI];
          bx_d  = bx_i[WIDTH-1:HI];
          sum_d = sum_all;
          c_d   = seg_cout;
          v_d   = v_i;
          sub_d = sub_i;
          sgn_d = sgn_i;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          bx_q  <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
          sub_q <= 1'b0;
          sgn_q <= 1'b0;
        end else begin
          a_q   <= a_d;
          bx_q  <= bx_d;
          sum_q <= sum_d;
          c_q   <= c_d;
          v_q   <= v_d;
          sub_q <= sub_d;
          sgn_q <= sgn_d;
        end
      end
    end else begin : g_fin
      logic a_msb, b_msb, s_msb;

      always_comb begin
        fin_valid = v_i;
        fin_cout  = seg_cout;
        fin_sum   = sum_all;
        a_msb     = a_i[WIDTH-1];
        b_msb     = bx_i[WIDTH-1];
        s_msb     = sum_all[WIDTH-1];
        if (sgn_i) fin_ovf = (a_msb == b_msb) && (s_msb != a_msb);
        else       fin_ovf = sub_i ? !seg_cout : seg_cout;
`ifdef CLA_PIPE_SAT_EN
        if (fin_ovf) begin
          if (!sgn_i) fin_sum = sub_i ? '0 : '1;
          else        fin_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    if (advance) begin
      out_valid_d = fin_valid;
      out_sum_d   = fin_sum;
      out_cout_d  = fin_cout;
      out_ovf_d   = fin_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub (WIDTH=32, STAGES=2); honours CLA_PIPE_SAT_EN.
`timescale 1ns/1ps
module tb_cla_pipe_addsub;
  localparam int unsigned W  = 32;
  localparam int unsigned ST = 2;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_sub = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_cout, out_ovf;
  logic [W-1:0] out_sum;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, stalls = 0, ready_mode = 0;

  cla_pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.cyc = 0; e.stl = 0;
    return e;
  endfunction

  // Reference: true integer arithmetic, then wrap / range checks.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic sgn);
    exp_t   e;
    longint ua, ub, sa, sb, r;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    e  = mk(sub ? a - b : a + b, 1'b0, 1'b0);
    e.cout = sub ? (ua >= ub) : ((ua + ub) > 64'sh0_FFFF_FFFF);
    if (sgn) begin
      r     = sub ? sa - sb : sa + sb;
      e.ovf = (r > SMAX) || (r < SMIN);
    end else begin
      e.ovf = sub ? (ua < ub) : ((ua + ub) > 64'sh0_FFFF_FFFF);
    end
`ifdef CLA_PIPE_SAT_EN
    if (e.ovf) begin
      if (!sgn) e.sum = sub ? 32'h0 : 32'hFFFF_FFFF;
      else      e.sum = (r > SMAX) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end
`endif
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic sgn, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_signed = sgn;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail("accept_timeout");
    else begin
      e.cyc = cyc;
      e.stl = stalls;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    logic [31:0] a, b;
    logic        sub, sgn;
    a   = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF << $urandom_range(0, 1) : $urandom();
    b   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF >> $urandom_range(0, 1) : $urandom();
    sub = 1'($urandom_range(0, 1));
    sgn = 1'($urandom_range(0, 1));
    send(a, b, sub, sgn, model(a, b, sub, sgn));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = $urandom();
    in_b     = $urandom();
    in_sub   = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  // Downstream ready pattern: 0 always, 1 repeating 1,0,0, 2 random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = (ph % 3 == 0); ph++; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: protocol checks, hold-while-stalled, scoreboard pop with latency.
  initial begin
    logic        pstall, pc, po;
    logic [31:0] psum;
    exp_t        e;
    pstall = 1'b0; pc = 1'b0; po = 1'b0; psum = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 1'b0;
        continue;
      end
      chk("in_ready_vs_advance", 32'(in_ready), 32'(out_ready || !out_valid));
      if (pstall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", out_sum, psum);
        chk("hold_flags", {30'd0, out_cout, out_ovf}, {30'd0, pc, po});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) fail("unexpected_out_valid");
        else begin
          e = q.pop_front();
          chk("sum", out_sum, e.sum);
          chk("cout", 32'(out_cout), 32'(e.cout));
          chk("ovf", 32'(out_ovf), 32'(e.ovf));
          chk("latency", 32'(cyc - e.cyc), 32'(int'(ST) + stalls - e.stl));
        end
      end
      pstall = out_valid && !out_ready;
      if (pstall) begin
        stalls++;
        psum = out_sum; pc = out_cout; po = out_ovf;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_flags", {30'd0, out_cout, out_ovf}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

`ifdef CLA_PIPE_SAT_EN
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 1'b1));
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
    send(32'h8000_0000, 32'h1, 1'b1, 1'b1, mk(32'h8000_0000, 1'b1, 1'b1));
    send(32'd5, 32'd7, 1'b1, 1'b0, mk(32'h0, 1'b0, 1'b1));
`else
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b1));
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1));
    send(32'h8000_0000, 32'h1, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
    send(32'd5, 32'd7, 1'b1, 1'b0, mk(32'hFFFF_FFFE, 1'b0, 1'b1));
`endif
    send(32'd7, 32'd5, 1'b1, 1'b0, mk(32'd2, 1'b1, 1'b0));
    send(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0));
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b1, 1'b0));
    idle();

    ready_mode = 1;
    for (int i = 0; i < 8; i++) send_rand();
    idle();
    ready_mode = 0;
    repeat (8) idle();

    send_rand();
    send_rand();
    rst = 1'b1; in_valid = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_flush_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0));
    idle();

    for (int i = 0; i < 500; i++) send_rand();
    ready_mode = 2;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_rand();
    end

    in_valid = 1'b0;
    ready_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (q.size() != 0) fail("drain_timeout");
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor; the next generation of the team's fixed 32-bit combinational CLA adder. It keeps the two-level 4-bit group generate/propagate lookahead and adds four things: configurable operand width, configurable pipeline depth, an add/subtract and signed/unsigned mode per transaction, and a valid/ready handshake. It sits in datapath units that need a wide adder to close timing at full clock rate.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of 4.
- STAGES, 2: pipeline depth and latency in cycles; legal range is 1 to WIDTH/4.
- clk  in  1: single clock; all state is updated on the rising edge.
- rst  in  1: reset, synchronous and active-high.
- in_valid  in  1: input transaction present.
- in_ready  out  1: block accepts an input this cycle.
- in_a  in  WIDTH: operand A.
- in_b  in  WIDTH: operand B.
- in_sub  in  1: 0 computes A+B; 1 computes A−B.
- in_signed  in  1: 1 selects two's-complement overflow rules; 0 selects unsigned rules.
- out_valid  out  1: result present.
- out_ready  in  1: downstream accepts the result.
- out_sum  out  WIDTH: result.
- out_cout  out  1: raw carry out of the MSB.
- out_ovf  out  1: overflow for the selected mode.

## Operation
- Subtraction is computed as A + ~B + 1, with carry-in = in_sub.
- Per-bit terms: G = a&b', P = a|b', where b' is the conditionally inverted B. Each sum bit is a^b'^carry.
- Groups of 4 bits use 4-bit lookahead to form group G/P. Groups are chained by a 4-group lookahead level inside each pipeline segment.
- Width is split into STAGES segments, each of (WIDTH/4)/STAGES groups. When the division is uneven, the remainder groups go in the lowest segment.
  - Segment k adds bits in cycle k.
  - The segment carry-out is registered and feeds segment k+1.
  - Operands not yet consumed are delayed in skew registers alongside.
  - Completed low sum bits are delayed to the output (de-skew).
- out_cout is the raw carry. For subtraction, cout=1 means no borrow.
- out_ovf rules:
  - Unsigned add: cout.
  - Unsigned sub: !cout.
  - Signed: (a_msb == b'_msb) && (sum_msb != a_msb).
- in_sub and in_signed travel with their transaction through the pipeline.
- Flow control uses a global stall with no internal state machine:
  - advance = out_ready || !out_valid
  - in_ready = advance
  - When advance=1, every stage shifts, and the valid bits shift with it.
  - When advance=0, all stage registers hold.
  - Bubbles are not compressed.
- A transfer occurs when valid && ready on the same edge, at either port.

## Timing
- Latency is exactly STAGES cycles from input acceptance to out_valid, assuming no stall. Each stall cycle adds one cycle.
- Throughput is one result per cycle while out_ready=1.
- Reset values: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, all internal valid bits 0. in_ready=1 in the first cycle after reset.
- rst mid-operation discards all in-flight transactions. No output is produced for them.
- While out_valid=1 and out_ready=0:
  - out_sum, out_cout and out_ovf stay stable.
  - in_ready=0, and any offered input is not accepted.
- Simultaneous output drain and input accept in one cycle is allowed and loses nothing.
- in_a, in_b and the mode bits are sampled only on an accepted edge.
- STAGES=1 gives a single registered output stage. Lookahead is then fully combinational across WIDTH.

## Configuration
- CLA_PIPE_SAT_EN defined: when out_ovf=1, out_sum is clamped.
  - Unsigned add saturates to all-ones.
  - Unsigned sub saturates to 0.
  - Signed positive overflow saturates to 0111…1; signed negative overflow saturates to 1000…0.
  - out_cout and out_ovf still report raw values.
  - Latency is unchanged; the clamp is applied in the final stage.
- CLA_PIPE_SAT_EN undefined: out_sum is always the wrapped WIDTH-bit result.

## Test plan
All scenarios use WIDTH=32, STAGES=2.
- Unsigned add 0xFFFFFFFF + 0x00000001, out_ready=1 → 2 cycles later: sum 0x00000000, cout 1, ovf 1 (sum 0xFFFFFFFF with SAT).
- Signed add 0x7FFFFFFF + 0x00000001 → sum 0x80000000, ovf 1, cout 0 (sum 0x7FFFFFFF with SAT). Signed 0x80000000 − 1 → sum 0x7FFFFFFF, ovf 1 (sum 0x80000000 with SAT).
- Unsigned sub 5 − 7 → sum 0xFFFFFFFE, cout 0, ovf 1 (sum 0 with SAT). Unsigned sub 7 − 5 → sum 2, cout 1, ovf 0.
- Back-to-back stream of 8 accepted transactions with out_ready toggling 1,0,0,1… → results emerge in order and match a reference model; in_ready==advance every cycle; out_sum holds while stalled.
- Carry crossing the segment boundary: 0x0000FFFF + 0x00000001 → 0x00010000. Also 1000 random operand/mode vectors checked against a behavioural model.
- Assert rst with 2 transactions in flight → out_valid=0 on the next cycle and stays 0 until a new transaction is accepted; the next accepted transaction gives a correct result 2 cycles later.
